pwm_div_multi: RTL and testbench

- Parametrised multi-channel clock divider / PWM generator. Successor to the fixed 100 MHz -> 1 MHz divider.
- Each channel has its own counter with runtime-programmable period and duty, and its own enable.
- Configuration writes go to shadow registers and take effect only at the period boundary, so there are no glitches.
- Drives divided clocks and PWM strobes to downstream peripheral logic from the 100 MHz system clock.

---
 rtl/pwm_div_multi.sv | 146 ++++++++++++++
 tb/tb_pwm_div_multi.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_div_multi.sv
// pwm_div_multi: multi-channel clock divider / PWM generator on the 100 MHz system clock.
//
// Each channel runs its own up-counter with a runtime-programmable period (terminal count)
// and duty (number of high cycles per period). Configuration writes land in shadow
// registers and are copied to the active registers only at a period boundary, or right
// away while the channel is idle, so a running waveform is never cut short or glitched.
//
// Optional build macro: PWM_TICK_EN
//   Defined   -> adds output wrap_tick, a registered one-cycle pulse per channel in the
//                cnt==0 cycle that follows each wrap (never on the first enabled cycle).
//   Undefined -> the port and its logic are absent; everything else is identical.
//
// Ports:
//   clk_100m    in   system clock, all logic on the rising edge
//   rst         in   synchronous active-high reset
//   ch_en       in   [CH_NUM]  per-channel level-sensitive enable
//   cfg_we      in   one-cycle configuration write strobe
//   cfg_ch      in   [4]       target channel for cfg_we (indices >= CH_NUM are ignored)
//   cfg_period  in   [CNT_W]   new period (period length = value + 1 cycles)
//   cfg_duty    in   [CNT_W]   new duty (high cycles per period)
//   cfg_pending out  [CH_NUM]  shadow written but not yet applied
//   pwm_out     out  [CH_NUM]  registered PWM / divided-clock outputs
//   wrap_tick   out  [CH_NUM]  (PWM_TICK_EN only) registered wrap pulse

module pwm_div_multi #(
    parameter int CH_NUM     = 4,
    parameter int CNT_W      = 32,
    parameter int DEF_PERIOD = 99,
    parameter int DEF_DUTY   = 50
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic [CH_NUM-1:0] cfg_pending,
    output logic [CH_NUM-1:0] pwm_out
`ifdef PWM_TICK_EN
    ,
    output logic [CH_NUM-1:0] wrap_tick
`endif
);

    localparam logic [CNT_W-1:0] DEF_PERIOD_V = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_DUTY_V   = CNT_W'(DEF_DUTY);

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi = gi + 1) begin : g_ch
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [CNT_W-1:0] per_act_reg, per_act_next;
            logic [CNT_W-1:0] duty_act_reg, duty_act_next;
            logic [CNT_W-1:0] per_sh_reg, per_sh_next;
            logic [CNT_W-1:0] duty_sh_reg, duty_sh_next;
            logic             en_q_reg;
            logic             pend_reg, pend_next;
            logic             pwm_reg, pwm_next;
            logic             sel;
            logic             at_wrap;
            logic             apply;

            always_comb begin
                sel     = cfg_we && (cfg_ch == 4'(gi));
                at_wrap = ch_en[gi] && (cnt_reg == per_act_reg);
                // An idle channel has no waveform to protect, so it applies every cycle.
                apply   = at_wrap || !ch_en[gi];

                // A write in the apply cycle is taken straight through: the copy below
                // reads the *next* shadow values, so the new setting lands at this wrap
                // and pending never rises.
                per_sh_next  = sel ? cfg_period : per_sh_reg;
                duty_sh_next = sel ? cfg_duty   : duty_sh_reg;

                per_act_next  = per_act_reg;
                duty_act_next = duty_act_reg;
                pend_next     = pend_reg;
                if (apply) begin
                    per_act_next  = per_sh_next;
                    duty_act_next = duty_sh_next;
                    pend_next     = 1'b0;
                end else if (sel) begin
                    pend_next = 1'b1;
                end

                // en_q_reg gates the increment so the first enabled cycle shows cnt=0.
                if (ch_en[gi] && en_q_reg && !at_wrap) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end

                // Registered form of: pwm == en_q && (cnt < duty_act), using next values.
                pwm_next = ch_en[gi] && (cnt_next < duty_act_next);
            end

            always_ff @(posedge clk_100m) begin
                if (rst) begin
                    cnt_reg      <= '0;
                    per_act_reg  <= DEF_PERIOD_V;
                    duty_act_reg <= DEF_DUTY_V;
                    per_sh_reg   <= DEF_PERIOD_V;
                    duty_sh_reg  <= DEF_DUTY_V;
                    en_q_reg     <= 1'b0;
                    pend_reg     <= 1'b0;
                    pwm_reg      <= 1'b0;
                end else begin
                    cnt_reg      <= cnt_next;
                    per_act_reg  <= per_act_next;
                    duty_act_reg <= duty_act_next;
                    per_sh_reg   <= per_sh_next;
                    duty_sh_reg  <= duty_sh_next;
                    en_q_reg     <= ch_en[gi];
                    pend_reg     <= pend_next;
                    pwm_reg      <= pwm_next;
                end
            end

            assign pwm_out[gi]     = pwm_reg;
            assign cfg_pending[gi] = pend_reg;

`ifdef PWM_TICK_EN
            logic tick_reg;
            logic tick_next;

            // Only a wrap seen while already running counts; the enable transition
            // cycle (en_q low) never produces a tick.
            always_comb begin
                tick_next = ch_en[gi] && en_q_reg && at_wrap;
            end

            always_ff @(posedge clk_100m) begin
                if (rst) begin
                    tick_reg <= 1'b0;
                end else begin
                    tick_reg <= tick_next;
                end
            end

            assign wrap_tick[gi] = tick_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pwm_div_multi.sv
// Testbench for pwm_div_multi (CH_NUM=4, CNT_W=32, default period 99 / duty 50).
// Stimulus pushes the hand-computed post-edge expectation of every cycle into a queue;
// an independent monitor pops one entry on each falling edge and compares it.
// Build with PWM_TICK_EN defined to also check wrap_tick.

module tb_pwm_div_multi;

    logic        clk_100m = 1'b0;
    logic        rst;
    logic [3:0]  ch_en;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [31:0] cfg_period;
    logic [31:0] cfg_duty;
    logic [3:0]  cfg_pending;
    logic [3:0]  pwm_out;
`ifdef PWM_TICK_EN
    logic [3:0]  wrap_tick;
`endif

    always #5 clk_100m = ~clk_100m;

    pwm_div_multi #(
        .CH_NUM(4),
        .CNT_W(32),
        .DEF_PERIOD(99),
        .DEF_DUTY(50)
    ) dut (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_pending(cfg_pending),
        .pwm_out    (pwm_out)
`ifdef PWM_TICK_EN
        ,
        .wrap_tick  (wrap_tick)
`endif
    );

    typedef struct {
        logic [3:0] pwm;
        logic [3:0] pend;
        logic [3:0] tick;
        bit         chk_tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   mon_idx = 0;
    int   c0      = -1;   // ch0 position in its period-10 / duty-3 regime, -1 when not used

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %b, want %b", nm, mon_idx, act, exp_v);
        end
    endtask

    // Monitor: one expectation per clock, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100m);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pwm_out", pwm_out, e.pwm);
                check("cfg_pending", cfg_pending, e.pend);
`ifdef PWM_TICK_EN
                if (e.chk_tick) check("wrap_tick", wrap_tick, e.tick);
`endif
                mon_idx++;
            end
        end
    end

    // Advance one clock; expectation describes the state right after this edge.
    task automatic step(input logic [3:0] ep, input logic [3:0] epend,
                        input logic [3:0] etick, input bit ct);
        exp_t e;
        @(posedge clk_100m);
        e.pwm = ep;
        e.pend = epend;
        e.tick = etick;
        e.chk_tick = ct;
        sb_q.push_back(e);
        #1;
        cfg_we = 1'b0;
    endtask

    // Step with ch0 following its period-10 / duty-3 pattern (when c0 >= 0).
    task automatic step3(input logic [3:1] ep_hi, input logic [3:0] epend);
        logic b0;
        b0 = 1'b0;
        if (c0 >= 0) begin
            b0 = (c0 % 10) < 3;
            c0++;
        end
        step({ep_hi, b0}, epend, 4'b0000, 1'b0);
    endtask

    task automatic write_cfg(input logic [3:0] ch, input logic [31:0] per, input logic [31:0] duty);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = per;
        cfg_duty   = duty;
        $display("cfg write: ch=%0d period=%0d duty=%0d", ch, per, duty);
    endtask

    task automatic boundary(input logic [31:0] per, input logic [31:0] duty, input logic lvl);
        ch_en[1] = 1'b0;
        write_cfg(4'd1, per, duty);
        step3(3'b000, 4'b0000);
        ch_en[1] = 1'b1;
        repeat (20) step3({2'b00, lvl}, 4'b0000);
        ch_en[1] = 1'b0;
        step3(3'b000, 4'b0000);
    endtask

    initial begin
        logic b;
        logic e2;
        logic t;

        rst = 1'b1; ch_en = 4'b0000; cfg_we = 1'b0;
        cfg_ch = 4'd0; cfg_period = '0; cfg_duty = '0;

        // Reset state
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Defaults: period 100, 50 high, starting the cycle after enable
        rst = 1'b0;
        ch_en = 4'b0001;
        for (int k = 0; k < 300; k++) begin
            b = (k % 100) < 50;
            step({3'b000, b}, 4'b0000, 4'b0000, 1'b0);
        end

        // Shadowed update mid-period: pending until the 100-cycle period ends
        for (int k = 300; k < 460; k++) begin
            if (k == 320) write_cfg(4'd0, 32'd9, 32'd3);
            if (k < 400) b = (k - 300) < 50;
            else         b = ((k - 400) % 10) < 3;
            step({3'b000, b}, {3'b000, (k >= 320 && k < 400) ? 1'b1 : 1'b0}, 4'b0000, 1'b0);
        end
        c0 = 60;

        // Duty boundaries on ch1
        boundary(32'd4, 32'd0, 1'b0);
        boundary(32'd4, 32'd5, 1'b1);
        boundary(32'd0, 32'd1, 1'b1);

        // Collision on ch2 at its wrap, then an out-of-range channel index
        ch_en[2] = 1'b0;
        write_cfg(4'd2, 32'd7, 32'd2);
        step3(3'b000, 4'b0000);
        ch_en[2] = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            if (j == 8)  write_cfg(4'd2, 32'd4, 32'd4);
            if (j == 20) write_cfg(4'd7, 32'd1, 32'd1);
            if (j < 8) e2 = j < 2;
            else       e2 = ((j - 8) % 5) < 4;
            step3({1'b0, e2, 1'b0}, 4'b0000);
        end
        ch_en[2] = 1'b0;
        step3(3'b000, 4'b0000);

        // Reset mid-period with a pending write on ch0
        while ((c0 % 10) != 3) step3(3'b000, 4'b0000);
        write_cfg(4'd0, 32'd20, 32'd5);
        step3(3'b000, 4'b0001);
        rst = 1'b1;
        c0 = -1;
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);
        rst = 1'b0;
        ch_en = 4'b0000;
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Defaults restored; drop enable at cnt=30, then a full restart from cnt 0
        ch_en = 4'b0001;
        for (int j = 0; j <= 30; j++) step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        ch_en = 4'b0000;
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        ch_en = 4'b0001;
        for (int j = 0; j < 120; j++) begin
            b = (j % 100) < 50;
            step({3'b000, b}, 4'b0000, 4'b0000, 1'b0);
        end

        // Period 9 / duty 3: wrap pulse every 10 cycles, none on the first enabled cycle
        ch_en = 4'b0000;
        write_cfg(4'd0, 32'd9, 32'd3);
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);
        ch_en = 4'b0001;
        for (int j = 0; j < 40; j++) begin
            b = (j % 10) < 3;
            t = (j > 0) && ((j % 10) == 0);
            step({3'b000, b}, 4'b0000, {3'b000, t}, 1'b1);
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) @(negedge clk_100m);
        @(negedge clk_100m);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
